// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU definitions for the fetch sequencer: FSM states, opcode
// constants and the default reset PC.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_LATCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    localparam logic [3:0]  OP_BRANCH = 4'b1100;
    localparam logic [3:0]  OP_JUMP   = 4'b1000;
    localparam logic [15:0] RESET_PC  = 16'h0000;

    function automatic logic [15:0] sext8(input logic [7:0] value);
        return {{8{value[7]}}, value};
    endfunction

endpackage

// File: rtl/fetch_sequencer_decode.sv
// Combinational field extraction from the instruction register: opcode,
// condition, immediate/target select and register read index.
module instr_field_decode (
    input  logic [15:0] i_ir,
    input  logic [15:0] i_rtarget,
    output logic [7:0]  o_op,
    output logic [3:0]  o_cond,
    output logic [15:0] o_imm,
    output logic [3:0]  o_rsrc_idx
);
    import fetch_sequencer_pkg::*;

    assign o_op       = {i_ir[15:12], i_ir[7:4]};
    assign o_cond     = i_ir[11:8];
    assign o_rsrc_idx = i_ir[3:0];

    // Branches carry a signed displacement, jumps take a register target.
    always_comb begin
        o_imm = {8'h00, i_ir[7:0]};
        case (i_ir[15:12])
            OP_BRANCH: o_imm = sext8(i_ir[7:0]);
            OP_JUMP:   o_imm = i_rtarget;
            default:   o_imm = {8'h00, i_ir[7:0]};
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches a word, latches it, holds decoded
// fields until the datapath finishes, then takes the next PC.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC   = fetch_sequencer_pkg::RESET_PC,
    parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_data,
    output logic [15:0] pc_out,
    output logic [7:0]  op_out,
    output logic [3:0]  cond_out,
    output logic [15:0] imm_out,
    output logic [3:0]  rsrc_idx,
    input  logic [15:0] rtarget,
    input  logic [15:0] dis_in,
    input  logic        exec_done,
    output logic        instr_valid,
    output logic        halted
);
    import fetch_sequencer_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [15:0]  r_pc;
    logic [15:0]  r_ir;
    logic         w_load_ir;
    logic         w_load_pc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= 16'h0000;
        end else if (!stall) begin
            r_state <= w_next_state;
            if (w_load_ir) r_ir <= mem_data;
            if (w_load_pc) r_pc <= dis_in;
        end
    end

    // Status strobes are suppressed while reset is asserted so the reset
    // cycle itself shows an idle sequencer.
    always_comb begin
        w_next_state = r_state;
        w_load_ir    = 1'b0;
        w_load_pc    = 1'b0;
        mem_rd       = 1'b0;
        instr_valid  = 1'b0;
        halted       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_rd       = reset_n && !stall;
                w_next_state = ST_LATCH;
            end
            ST_LATCH: begin
                w_load_ir    = 1'b1;
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                instr_valid = reset_n;
                if (r_ir == HALT_INSTR) begin
                    w_next_state = ST_HALTED;
                end else if (exec_done) begin
                    w_load_pc    = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_HALTED: begin
                halted = reset_n;
            end
            default: w_next_state = ST_FETCH;
        endcase
    end

    assign mem_addr = r_pc;
    assign pc_out   = r_pc;

    instr_field_decode u_decode (
        .i_ir       (r_ir),
        .i_rtarget  (rtarget),
        .o_op       (op_out),
        .o_cond     (cond_out),
        .o_imm      (imm_out),
        .o_rsrc_idx (rsrc_idx)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_sequencer;

    localparam int PH_FETCH  = 0;
    localparam int PH_LATCH  = 1;
    localparam int PH_DECODE = 2;
    localparam int PH_HALTED = 3;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic [15:0] pc_out;
    logic [7:0]  op_out;
    logic [3:0]  cond_out;
    logic [15:0] imm_out;
    logic [3:0]  rsrc_idx;
    logic [15:0] rtarget;
    logic [15:0] dis_in;
    logic        exec_done;
    logic        instr_valid;
    logic        halted;

    int checks;
    int failures;

    int          mPhase;
    logic [15:0] mPc;
    logic [15:0] mIr;
    logic        lastRd;
    logic [15:0] lastAddr;
    logic [15:0] memImg [int];

    fetch_sequencer #(
        .RESET_PC   (16'h0000),
        .HALT_INSTR (16'hFFFF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .pc_out      (pc_out),
        .op_out      (op_out),
        .cond_out    (cond_out),
        .imm_out     (imm_out),
        .rsrc_idx    (rsrc_idx),
        .rtarget     (rtarget),
        .dis_in      (dis_in),
        .exec_done   (exec_done),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] expImm(input logic [15:0] ir, input logic [15:0] rt);
        int low;
        int top;
        low = int'(ir[7:0]);
        top = int'(ir[15:12]);
        if (top == 12) return (low >= 128) ? 16'(low + 65536 - 256) : 16'(low);
        if (top == 8) return rt;
        return 16'(low);
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory answers the cycle after a read strobe and otherwise holds its output.
    task automatic applyStimulus(input logic st, input logic ex, input logic [15:0] dis,
                                 input logic [15:0] rt, input logic rn);
        if (lastRd) begin
            if (!memImg.exists(int'(lastAddr)))
                memImg[int'(lastAddr)] = ($urandom_range(0, 39) == 0) ? 16'hFFFF : 16'($urandom);
            mem_data = memImg[int'(lastAddr)];
        end
        stall     = st;
        exec_done = ex;
        dis_in    = dis;
        rtarget   = rt;
        reset_n   = rn;
        @(negedge clk);
    endtask

    task automatic checkOutput();
        logic expRd;
        expRd = reset_n && !stall && (mPhase == PH_FETCH);
        cmp("mem_rd", {15'd0, mem_rd}, {15'd0, expRd});
        if (mPhase == PH_FETCH) cmp("mem_addr", mem_addr, mPc);
        cmp("instr_valid", {15'd0, instr_valid}, {15'd0, reset_n && mPhase == PH_DECODE});
        cmp("halted", {15'd0, halted}, {15'd0, reset_n && mPhase == PH_HALTED});
        cmp("pc_out", pc_out, mPc);
        cmp("op_out", {8'd0, op_out}, {8'd0, mIr[15:12], mIr[7:4]});
        cmp("cond_out", {12'd0, cond_out}, {12'd0, mIr[11:8]});
        cmp("rsrc_idx", {12'd0, rsrc_idx}, {12'd0, mIr[3:0]});
        cmp("imm_out", imm_out, expImm(mIr, rtarget));
        lastRd   = expRd;
        lastAddr = mPc;
    endtask

    // Model advances by the sequencer's rules using the inputs present at the edge.
    task automatic advance();
        @(posedge clk);
        if (!reset_n) begin
            mPhase = PH_FETCH;
            mPc    = 16'h0000;
            mIr    = 16'h0000;
        end else if (!stall) begin
            case (mPhase)
                PH_FETCH:  mPhase = PH_LATCH;
                PH_LATCH:  begin mIr = mem_data; mPhase = PH_DECODE; end
                PH_DECODE: begin
                    if (mIr == 16'hFFFF) mPhase = PH_HALTED;
                    else if (exec_done) begin mPc = dis_in; mPhase = PH_FETCH; end
                end
                default:   mPhase = PH_HALTED;
            endcase
        end
        #1;
    endtask

    task automatic cyc(input logic st, input logic ex, input logic [15:0] dis,
                       input logic [15:0] rt, input logic rn);
        applyStimulus(st, ex, dis, rt, rn);
        checkOutput();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mPhase   = PH_FETCH;
        mPc      = 16'h0000;
        mIr      = 16'h0000;
        lastRd   = 1'b0;
        lastAddr = 16'h0000;
        mem_data = 16'h0000;
        stall = 1'b0; exec_done = 1'b0; dis_in = 16'h0; rtarget = 16'h0; reset_n = 1'b0;
        memImg[16'h0000] = 16'h1234;
        memImg[16'h0001] = 16'hC1FE;
        memImg[16'h0002] = 16'h8C05;
        memImg[16'h0400] = 16'hFFFF;
        memImg[16'hFFFF] = 16'h1111;

        // Reset, then a plain instruction at address 0.
        cyc(0, 0, 16'h0, 16'h0, 0); advance();
        cyc(0, 0, 16'h0, 16'h0, 0);
        cmp("rst_mem_rd", {15'd0, mem_rd}, 16'h0);
        advance();
        cyc(0, 0, 16'h0, 16'h0, 1);
        cmp("c1_mem_rd", {15'd0, mem_rd}, 16'h1);
        cmp("c1_mem_addr", mem_addr, 16'h0000);
        cmp("rst_pc", pc_out, 16'h0000);
        advance();
        cyc(0, 0, 16'h0, 16'h0, 1);
        cmp("c2_mem_rd", {15'd0, mem_rd}, 16'h0);
        advance();
        cyc(0, 1, 16'h0001, 16'h0, 1);
        cmp("c3_valid", {15'd0, instr_valid}, 16'h1);
        cmp("c3_op", {8'd0, op_out}, 16'h0013);
        advance();
        cyc(0, 0, 16'h0, 16'h0, 1);
        cmp("c4_mem_rd", {15'd0, mem_rd}, 16'h1);
        cmp("c4_pc", pc_out, 16'h0001);
        advance();

        // Branch word, with stalls in DECODE ignoring exec_done.
        cyc(0, 0, 16'h0, 16'h0, 1); advance();
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 16'h0002, 16'h0, 1);
            cmp("br_op", {8'd0, op_out}, 16'h00CF);
            cmp("br_cond", {12'd0, cond_out}, 16'h0001);
            cmp("br_imm", imm_out, 16'hFFFE);
            cmp("dec_stall_pc", pc_out, 16'h0001);
            advance();
        end
        cyc(0, 1, 16'h0002, 16'h0, 1);
        cmp("br_valid", {15'd0, instr_valid}, 16'h1);
        advance();

        // Jump word, with stalls in FETCH and LATCH.
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 16'h0, 16'h0, 1);
            cmp("fetch_stall_rd", {15'd0, mem_rd}, 16'h0);
            cmp("fetch_stall_pc", pc_out, 16'h0002);
            advance();
        end
        cyc(0, 0, 16'h0, 16'h0, 1);
        cmp("jmp_fetch_rd", {15'd0, mem_rd}, 16'h1);
        advance();
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 16'h0, 16'h0, 1);
            cmp("latch_stall_op", {8'd0, op_out}, 16'h00CF);
            cmp("latch_stall_rd", {15'd0, mem_rd}, 16'h0);
            advance();
        end
        cyc(0, 0, 16'h0, 16'h0, 1); advance();
        cyc(0, 1, 16'h0400, 16'h0400, 1);
        cmp("jmp_rsrc", {12'd0, rsrc_idx}, 16'h0005);
        cmp("jmp_imm", imm_out, 16'h0400);
        advance();
        cyc(0, 0, 16'h0, 16'h0, 1);
        cmp("jmp_target", mem_addr, 16'h0400);
        advance();

        // Halt word, exec_done while halted, then reset.
        cyc(0, 0, 16'h0, 16'h0, 1); advance();
        cyc(0, 1, 16'h1234, 16'h0, 1); advance();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 16'h5555, 16'h0, 1);
            cmp("halt_flag", {15'd0, halted}, 16'h1);
            cmp("halt_valid", {15'd0, instr_valid}, 16'h0);
            cmp("halt_pc", pc_out, 16'h0400);
            advance();
        end
        cyc(0, 0, 16'h0, 16'h0, 0); advance();
        cyc(0, 0, 16'h0, 16'h0, 1);
        cmp("unhalt_pc", pc_out, 16'h0000);
        cmp("unhalt_flag", {15'd0, halted}, 16'h0);
        advance();

        // PC wrap from FFFF, then reset overriding exec_done in DECODE.
        cyc(0, 0, 16'h0, 16'h0, 1); advance();
        cyc(0, 1, 16'hFFFF, 16'h0, 1); advance();
        cyc(0, 0, 16'h0, 16'h0, 1);
        cmp("wrap_addr_hi", mem_addr, 16'hFFFF);
        advance();
        cyc(0, 0, 16'h0, 16'h0, 1); advance();
        cyc(0, 1, 16'h0000, 16'h0, 1); advance();
        cyc(0, 0, 16'h0, 16'h0, 1);
        cmp("wrap_addr_lo", mem_addr, 16'h0000);
        advance();
        cyc(0, 0, 16'h0, 16'h0, 1); advance();
        cyc(1, 1, 16'hABCD, 16'h0, 0); advance();
        cyc(0, 0, 16'h0, 16'h0, 1);
        cmp("rst_dec_pc", pc_out, 16'h0000);
        cmp("rst_dec_rd", {15'd0, mem_rd}, 16'h1);
        advance();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 3) == 0), $urandom_range(0, 1), 16'($urandom),
                16'($urandom), ($urandom_range(0, 59) != 0));
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have parameter HALT_INSTR, default 16'hFFFF: instruction word that halts sequencing.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port stall  input  1  freezes all state while high.
REQ-006 SHALL have port mem_addr  output  16  instruction memory address.
REQ-007 SHALL have port mem_rd  output  1  instruction read strobe.
REQ-008 SHALL have port mem_data  input  16  instruction word, valid one cycle after a mem_rd cycle.
REQ-009 SHALL have port pc_out  output  16  current PC, feeds the displacement unit's pc_in.
REQ-010 SHALL have port op_out  output  8  {ir[15:12], ir[7:4]}, feeds the displacement unit's op.
REQ-011 SHALL have port cond_out  output  4  ir[11:8], feeds the displacement unit's condition.
REQ-012 SHALL have port imm_out  output  16  displacement or target, feeds the displacement unit's imm_in.
REQ-013 SHALL have port rsrc_idx  output  4  ir[3:0], register-file read index for the jump target.
REQ-014 SHALL have port rtarget  input  16  register value addressed by rsrc_idx.
REQ-015 SHALL have port dis_in  input  16  next PC from the displacement unit.
REQ-016 SHALL have port exec_done  input  1  datapath has finished the current instruction.
REQ-017 SHALL have port instr_valid  output  1  decoded fields are valid.
REQ-018 SHALL have port halted  output  1  sequencer is in HALTED.

Function
REQ-019 SHALL implement the states FETCH, LATCH, DECODE and HALTED.
REQ-020 In FETCH, mem_addr SHALL equal pc and mem_rd SHALL be 1; the next state SHALL be LATCH; mem_rd SHALL be 0 in every other state.
REQ-021 In LATCH, the instruction register ir SHALL capture mem_data; the next state SHALL be DECODE.
REQ-022 In DECODE, instr_valid SHALL be 1; if ir == HALT_INSTR the next state SHALL be HALTED, else on exec_done=1 pc SHALL load dis_in and the next state SHALL be FETCH, else the FSM SHALL stay in DECODE.
REQ-023 imm_out SHALL be sign-extended ir[7:0] when ir[15:12]==4'b1100 (branch); rtarget when ir[15:12]==4'b1000 (jump); zero-extended ir[7:0] otherwise.
REQ-024 pc_out, op_out, cond_out and imm_out SHALL be driven from registered pc and ir; they SHALL hold stable from LATCH exit until the next DECODE exit.
REQ-025 Minimum instruction latency SHALL be 3 cycles (FETCH, LATCH, DECODE with exec_done=1).
REQ-026 stall=1 SHALL hold state, pc and ir unchanged and SHALL force mem_rd=0; exec_done SHALL be ignored during stall; a FETCH cycle under stall SHALL be repeated.
REQ-027 pc SHALL wrap modulo 2^16 with no error indication; dis_in is used as supplied.
REQ-028 HALTED SHALL be exited only by reset; in HALTED, halted=1, instr_valid=0 and pc SHALL be frozen.
REQ-029 When stall and reset_n=0 coincide, reset SHALL win.

Reset
REQ-030 On reset_n=0 at a clock edge: state=FETCH, pc=RESET_PC, ir=16'h0000, halted=0, instr_valid=0, mem_rd=0 in that cycle.
REQ-031 Reset mid-instruction SHALL abandon the instruction without loading dis_in.

Structure
REQ-032 State encodings, opcode constants OP_BRANCH=4'b1100 and OP_JUMP=4'b1000, and RESET_PC SHALL live in the shared CPU package.
REQ-033 Field extraction (op, cond, imm select, rsrc_idx) SHALL be one combinational sub-module, instr_field_decode.

Verification
REQ-034 Reset then run: mem_data=16'h1234 at addr 0 with exec_done=1 in DECODE, dis_in=16'h0001 -> mem_rd at cycles 1 and 4, op_out=8'h13, pc_out=16'h0001 after cycle 3.
REQ-035 Branch: ir=16'hC1FE -> op_out=8'hCF, cond_out=4'h1, imm_out=16'hFFFE.
REQ-036 Jump: ir=16'h8C05 with rtarget=16'h0400 -> rsrc_idx=4'h5, imm_out=16'h0400; dis_in=16'h0400 with exec_done -> next mem_addr=16'h0400.
REQ-037 Stall for 2 cycles in each of FETCH, LATCH and DECODE -> no mem_rd under stall, ir and pc unchanged, exec_done under stall ignored.
REQ-038 ir=16'hFFFF -> halted=1 next cycle; exec_done pulses leave pc unchanged; reset_n=0 -> pc=RESET_PC, halted=0.
REQ-039 pc=16'hFFFF, dis_in=16'h0000 -> next fetch at 16'h0000; reset asserted in DECODE with exec_done=1 -> pc=RESET_PC, not dis_in.
